// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and defaults for the SAR code assembler
package sar_pkg;

    localparam int SAR_NBITS = 4;

    typedef enum logic {IDLE, CONV} sar_state_t;

    typedef logic [SAR_NBITS-1:0] sar_code_t;

endpackage

// File: rtl/sar_out_fifo.sv
// rtl/sar_out_fifo.sv - 2-entry valid/ready buffer for completed SAR codes
// Head is a dedicated register so DOUT keeps the last popped code while empty.
module sar_out_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         DVALID,
    input  logic         DREADY,
    output logic [W-1:0] DOUT
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         pop;
    logic         push_ok;

    assign DVALID  = (count_q != 2'd0);
    assign full    = (count_q == 2'(DEPTH));
    assign pop     = DVALID && DREADY;
    assign push_ok = push && (!full || pop);
    assign DOUT    = head_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            if (pop && full)
                head_q <= tail_q;
            // A push lands in the head when the head slot is (or becomes) free,
            // otherwise behind it; a full buffer only takes it alongside a pop.
            if (push) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop))
                    head_q <= push_data;
                else if (count_q == 2'd1 || pop)
                    tail_q <= push_data;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/sar_code_assembler.sv
// rtl/sar_code_assembler.sv - SAR trial register, code assembly and output buffering
// Restarting SARRST always wins over the pending decision, including the last one.
module sar_code_assembler
    import sar_pkg::*;
#(
    parameter int NBITS      = SAR_NBITS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             SARRST,
    input  logic             VCOMP,
    output logic [NBITS-1:0] DACB,
    output logic             BUSY,
    output logic             EOC,
    output logic [NBITS-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             OVF,
    input  logic             OVF_CLR,
    output logic             ABORT
);

    localparam int IDX_W = $clog2(NBITS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NBITS - 1);

    sar_state_t       state_q, state_d;
    logic [NBITS-1:0] dacb_q, dacb_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             push;
    logic             abort_d;
    logic             eoc_q, abort_q, ovf_q;
    logic             full;
    logic             drop;
    logic [NBITS-1:0] push_data;

    assign push_data = {dacb_q[NBITS-1:1], VCOMP};

    always_comb begin
        state_d = state_q;
        dacb_d  = dacb_q;
        idx_d   = idx_q;
        push    = 1'b0;
        abort_d = 1'b0;
        if (SARRST) begin
            abort_d = (state_q == CONV);
            state_d = CONV;
            dacb_d  = {1'b1, {(NBITS-1){1'b0}}};
            idx_d   = IDX_TOP;
        end else if (state_q == CONV) begin
            dacb_d[idx_q] = VCOMP;
            if (idx_q != '0) begin
                dacb_d[idx_q - 1'b1] = 1'b1;
                idx_d = idx_q - 1'b1;
            end else begin
                push    = 1'b1;
                state_d = IDLE;
                dacb_d  = '0;
            end
        end
    end

    // The pop seen here is the one the buffer performs on this same edge.
    assign drop = push && full && !(DVALID && DREADY);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            dacb_q  <= '0;
            idx_q   <= '0;
            eoc_q   <= 1'b0;
            abort_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dacb_q  <= dacb_d;
            idx_q   <= idx_d;
            eoc_q   <= push;
            abort_q <= abort_d;
            if (drop)
                ovf_q <= 1'b1;
            else if (OVF_CLR)
                ovf_q <= 1'b0;
        end
    end

    sar_out_fifo #(
        .W     (NBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .DVALID    (DVALID),
        .DREADY    (DREADY),
        .DOUT      (DOUT)
    );

    assign DACB  = dacb_q;
    assign BUSY  = (state_q == CONV);
    assign EOC   = eoc_q;
    assign ABORT = abort_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_sar_code_assembler.sv
// tb/tb_sar_code_assembler.sv - directed bench with a queue-based reference model
module tb_sar_code_assembler;

    localparam int NB = 4;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          SARRST = 1'b0;
    logic          VCOMP = 1'b0;
    logic          DREADY = 1'b0;
    logic          OVF_CLR = 1'b0;
    logic [NB-1:0] DACB;
    logic [NB-1:0] DOUT;
    logic          BUSY, EOC, DVALID, OVF, ABORT;

    int total = 0;
    int bad = 0;

    bit m_active;
    int m_nd;
    int m_code;
    int m_q[$];
    bit m_ovf, m_eoc, m_abort;
    int m_last;
    bit cmp_en = 1'b0;
    int eoc_count = 0;

    always #5 CLK = ~CLK;

    sar_code_assembler #(.NBITS(NB), .FIFO_DEPTH(2)) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .SARRST  (SARRST),
        .VCOMP   (VCOMP),
        .DACB    (DACB),
        .BUSY    (BUSY),
        .EOC     (EOC),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .DREADY  (DREADY),
        .OVF     (OVF),
        .OVF_CLR (OVF_CLR),
        .ABORT   (ABORT)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decisions so far occupy the top bits, the bit under trial is 1, rest 0.
    function automatic int exp_dacb();
        if (!m_active) return 0;
        return (m_code << (NB - m_nd)) | (1 << (NB - 1 - m_nd));
    endfunction

    function automatic int exp_dout();
        if (m_q.size() != 0) return m_q[0];
        return m_last;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_nd = 0;
        m_code = 0;
        m_q.delete();
        m_ovf = 1'b0;
        m_eoc = 1'b0;
        m_abort = 1'b0;
        m_last = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input bit r, input bit c);
        bit push;
        bit pop;
        bit dropped;
        push = 1'b0;
        dropped = 1'b0;
        pop = (m_q.size() != 0) && r;
        m_eoc = 1'b0;
        m_abort = 1'b0;
        if (s) begin
            m_abort = m_active;
            m_active = 1'b1;
            m_nd = 0;
            m_code = 0;
        end else if (m_active) begin
            m_code = m_code * 2 + int'(v);
            m_nd++;
            if (m_nd == NB) begin
                m_active = 1'b0;
                m_eoc = 1'b1;
                push = 1'b1;
            end
        end
        if (pop) m_last = m_q.pop_front();
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(m_code);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic step(input bit s, input bit v, input bit r, input bit c);
        SARRST = s;
        VCOMP = v;
        DREADY = r;
        OVF_CLR = c;
        @(posedge CLK);
        model_edge(s, v, r, c);
        #2;
    endtask

    task automatic conv(input int code, input bit rdy_last, input bit clr_last);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = NB - 1; i >= 0; i--)
            step(1'b0, code[i], (i == 0) ? rdy_last : 1'b0, (i == 0) ? clr_last : 1'b0);
    endtask

    always @(negedge CLK) begin
        if (cmp_en && RESETN) begin
            check("m_dacb", int'(DACB), exp_dacb());
            check("m_busy", int'(BUSY), int'(m_active));
            check("m_eoc", int'(EOC), int'(m_eoc));
            check("m_abort", int'(ABORT), int'(m_abort));
            check("m_dvalid", int'(DVALID), int'(m_q.size() != 0));
            check("m_dout", int'(DOUT), exp_dout());
            check("m_ovf", int'(OVF), int'(m_ovf));
            if (EOC) eoc_count++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        RESETN = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check("rst_dacb", int'(DACB), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_eoc", int'(EOC), 0);
        check("rst_dout", int'(DOUT), 0);
        check("rst_dvalid", int'(DVALID), 0);
        check("rst_ovf", int'(OVF), 0);
        check("rst_abort", int'(ABORT), 0);
        RESETN = 1'b1;
        cmp_en = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_dvalid", int'(DVALID), 0);
        check("idle_dacb", int'(DACB), 0);

        // single conversion 1,0,1,1 -> 0xB
        eoc_count = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("s_dacb0", int'(DACB), 8);
        check("s_busy", int'(BUSY), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("s_dacb1", int'(DACB), 12);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("s_dacb2", int'(DACB), 10);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("s_dacb3", int'(DACB), 11);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("s_dacb4", int'(DACB), 0);
        check("s_eoc", int'(EOC), 1);
        check("s_dvalid", int'(DVALID), 1);
        check("s_dout", int'(DOUT), 11);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("s_popped", int'(DVALID), 0);
        check("s_hold", int'(DOUT), 11);
        check("s_eoc_n", eoc_count, 1);

        // abort then restart, 0,0,0,1 -> 0x1
        eoc_count = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("a_dacb1", int'(DACB), 12);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("a_abort", int'(ABORT), 1);
        check("a_dacb", int'(DACB), 8);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("a_abort_off", int'(ABORT), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("a_dout", int'(DOUT), 1);
        check("a_dvalid", int'(DVALID), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("a_eoc_n", eoc_count, 1);

        // overflow: 0x3, 0x5 kept, 0x9 dropped
        conv(3, 1'b0, 1'b0);
        conv(5, 1'b0, 1'b0);
        conv(9, 1'b0, 1'b0);
        check("o_eoc", int'(EOC), 1);
        check("o_ovf", int'(OVF), 1);
        check("o_dout", int'(DOUT), 3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("o_dout2", int'(DOUT), 5);
        check("o_dvalid2", int'(DVALID), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("o_empty", int'(DVALID), 0);
        check("o_ovf_sticky", int'(OVF), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("o_ovf_clr", int'(OVF), 0);

        // full buffer, pop on the completing edge of 0xC
        conv(3, 1'b0, 1'b0);
        conv(5, 1'b0, 1'b0);
        conv(12, 1'b1, 1'b0);
        check("p_ovf", int'(OVF), 0);
        check("p_dout", int'(DOUT), 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("p_dout2", int'(DOUT), 12);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("p_empty", int'(DVALID), 0);

        // drop and clear on the same edge: set wins
        conv(3, 1'b0, 1'b0);
        conv(5, 1'b0, 1'b0);
        conv(9, 1'b0, 1'b1);
        check("c_ovf", int'(OVF), 1);

        // asynchronous reset mid-conversion
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        cmp_en = 1'b0;
        RESETN = 1'b0;
        #1;
        check("r_dacb", int'(DACB), 0);
        check("r_busy", int'(BUSY), 0);
        check("r_dvalid", int'(DVALID), 0);
        check("r_ovf", int'(OVF), 0);
        model_reset();
        @(negedge CLK);
        RESETN = 1'b1;
        cmp_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("r_dout", int'(DOUT), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sar_code_assembler.md
Name: sar_code_assembler

Overview:
- Downstream of the SAR sequencing FSM. Consumes the one-cycle sample strobe SARRST and the comparator decision VCOMP.
- Runs the successive-approximation trial register that drives the capacitive DAC, bit by bit, and assembles the final conversion code.
- Completed codes go into a 2-entry output buffer. The digital back end drains it through a valid/ready handshake.

Parameters:
- NBITS, 4, conversion resolution in bits; legal range 2..8.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- CLK  in  1  conversion clock, same clock as the sequencing FSM.
- RESETN  in  1  asynchronous active-low reset.
- SARRST  in  1  sample-phase strobe from the sequencer; high for one CLK cycle starts a conversion.
- VCOMP  in  1  comparator decision; 1 means Vin > Vdac, so keep the trial bit.
- DACB  out  NBITS  trial code to the capacitive DAC switches.
- BUSY  out  1  high while a conversion is in progress.
- EOC  out  1  one-cycle pulse when a code is completed, whether or not it is dropped.
- DOUT  out  NBITS  head-of-buffer code.
- DVALID  out  1  DOUT holds a valid code.
- DREADY  in  1  consumer accepts DOUT this cycle.
- OVF  out  1  sticky flag: a completed code was dropped because the buffer was full.
- OVF_CLR  in  1  synchronous clear of OVF.
- ABORT  out  1  one-cycle pulse when a conversion was restarted by SARRST before it finished.

Behaviour:
- Clock and reset:
  - One clock, CLK, rising edge.
  - Reset RESETN is asynchronous, active-low.
  - During reset, all outputs are 0: DACB, BUSY, EOC, DOUT, DVALID, OVF, ABORT. Buffer is empty, state is IDLE, bit index is 0.
- States: IDLE and CONV.
- IDLE:
  - DACB = 0.
  - SARRST=1 at a CLK edge -> CONV, DACB = 1 followed by zeros (MSB only), bit index = NBITS-1, BUSY=1.
- CONV, on each edge at bit index i:
  - DACB[i] <= VCOMP.
  - If i > 0: DACB[i-1] <= 1 and i <= i-1.
  - If i = 0: the code is DACB[NBITS-1:1] concatenated with VCOMP. Push it to the buffer, pulse EOC, go to IDLE, clear DACB and BUSY.
- Latency:
  - The SARRST edge is cycle 0. VCOMP is sampled at edges 1..NBITS.
  - EOC is high in the cycle after edge NBITS.
  - DVALID rises in the same cycle if the buffer was empty.
- SARRST during CONV (edges 1..NBITS):
  - Abort the current conversion; no push.
  - Pulse ABORT and restart exactly as from IDLE, with DACB = MSB only and i = NBITS-1.
  - SARRST on the final-decision edge also aborts; EOC does not pulse.
- VCOMP in IDLE is ignored.
- Output buffer:
  - FIFO order. DOUT shows the head entry.
  - A pop occurs when DVALID and DREADY are both high at an edge.
  - DOUT is held stable while DVALID=1 and DREADY=0.
  - When empty, DVALID=0 and DOUT keeps its last value (0 after reset).
- Push when full:
  - If a pop happens on the same edge, the push is accepted: occupancy stays 2 and order is preserved.
  - Otherwise the new code is dropped, OVF is set, and EOC still pulses.
- OVF:
  - Cleared by OVF_CLR=1 at an edge.
  - If a set and a clear occur on the same edge, set wins.
- Reset mid-conversion discards the partial code and all buffer contents.

Decomposition:
- Shared package sar_pkg:
  - SAR_NBITS default constant.
  - State enum {IDLE, CONV}.
  - Code typedef of width NBITS.
- One natural sub-module, sar_out_fifo:
  - 2-entry valid/ready buffer.
  - Ports: push, push_data, full, DVALID, DREADY, DOUT.
  - Drop and OVF logic stays in the parent.

Test Plan:
- Reset behaviour: NBITS=4, RESETN low then released, no SARRST -> all outputs 0, DVALID stays 0.
- Single conversion:
  - Stimulus: SARRST pulse, then VCOMP = 1,0,1,1 on edges 1..4, with DREADY=1.
  - DACB sequence: 1000, 1100, 1010, 1011, then 0000.
  - EOC pulses once, DVALID=1 with DOUT=0xB for one cycle, then pops.
- Abort:
  - Stimulus: SARRST, VCOMP=1 on edge 1, SARRST again at edge 2.
  - ABORT pulses and DACB returns to 1000.
  - Then VCOMP = 0,0,0,1 -> DOUT=0x1, and only one EOC for the whole sequence.
- Overflow:
  - Stimulus: DREADY=0, three back-to-back conversions yielding 0x3, 0x5, 0x9.
  - Buffer holds 0x3 then 0x5. Third EOC pulses, OVF=1, and 0x9 is dropped.
  - Raising DREADY drains 0x3 then 0x5, then DVALID=0.
- Push with simultaneous pop:
  - Stimulus: buffer full (0x3, 0x5), DREADY=1 on the edge that completes 0xC.
  - No OVF. Drain order is 0x5 then 0xC.
- OVF_CLR and reset mid-conversion:
  - OVF_CLR asserted on the same edge as a new drop -> OVF remains 1.
  - RESETN asserted mid-conversion -> DACB, BUSY, DVALID go to 0 immediately, without waiting for CLK.
